// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the shift-add multiplier: default
//               operand width, iteration counter width and the controller
//               state encoding. Also imported by the Product and ALU blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Default operand width; also the number of add/shift iterations.
    localparam int c_MULT_WIDTH = 32;
    // Iteration counter width; 2**c_MULT_CNT_W must exceed c_MULT_WIDTH.
    localparam int c_MULT_CNT_W = 6;

    // Controller state encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CALC = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_LOAD = LOAD,
        ST_CALC = CALC,
        ST_DONE = DONE
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/multiplier_control.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_control
// Description : Sequencing controller for the unsigned shift-add multiplier.
//               Loads the operands on a start request, then steps the Product
//               register through WIDTH add/shift iterations, choosing add or
//               shift-only from the Product LSB, and flags completion.
//
// Ports       : clk            - clock; controller updates on posedge, the
//                                Product register on negedge
//               rst            - asynchronous active-high reset
//               start          - multiply request (honoured in IDLE/DONE)
//               lsb            - Product bit 0
//               ld_mcand       - multiplicand register capture pulse
//               alu_zero       - forces ALU result to zero (Product init)
//               w_ctrl_Product - Product load strobe
//               adding_ctrl    - 1 = add then shift, 0 = shift only
//               busy           - high in LOAD and CALC
//               rdy            - result valid, high only in DONE
//               iter_cnt       - remaining iterations
//
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_control
    import mult_pkg::*;
#(
    parameter int WIDTH = c_MULT_WIDTH,
    parameter int CNT_W = c_MULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lsb,
    output logic             ld_mcand,
    output logic             alu_zero,
    output logic             w_ctrl_Product,
    output logic             adding_ctrl,
    output logic             busy,
    output logic             rdy,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_iter_cnt;
    logic [CNT_W-1:0] w_iter_cnt_nxt;
    logic             w_dec_en;

    // ------------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_iter_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_iter_cnt <= w_iter_cnt_nxt;
        end
    end

    // The counter only ever moves down while calculating, and never below
    // zero, so it cannot wrap even if the state register is disturbed.
    assign w_dec_en = (r_state == ST_CALC) && (r_iter_cnt != '0);

    // ------------------------------------------------------------------------
    // Next-state, counter and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_iter_cnt_nxt = r_iter_cnt;
        ld_mcand       = 1'b0;
        alu_zero       = 1'b0;
        w_ctrl_Product = 1'b0;
        adding_ctrl    = 1'b0;
        busy           = 1'b0;
        rdy            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Capture multiplicand and load Product = {0, multiplier}.
                ld_mcand       = 1'b1;
                alu_zero       = 1'b1;
                w_ctrl_Product = 1'b1;
                busy           = 1'b1;
                w_iter_cnt_nxt = c_CNT_LOAD;
                w_state_nxt    = ST_CALC;
            end

            ST_CALC: begin
                busy = 1'b1;
                // Mealy output: lsb settles at the negedge preceding this
                // cycle and the Product consumes it at the next negedge.
                adding_ctrl = lsb;
                if (w_dec_en) begin
                    w_iter_cnt_nxt = r_iter_cnt - c_CNT_ONE;
                end
                // A zero count here is illegal; leaving on it as well keeps
                // the controller from hanging if it ever happens.
                if (r_iter_cnt <= c_CNT_ONE) begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                rdy = 1'b1;
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_iter_cnt_nxt = '0;
            end
        endcase
    end

    assign iter_cnt = r_iter_cnt;

`ifndef SYNTHESIS
    // The counter must still hold iterations whenever CALC is active.
    a_cnt_nonzero_in_calc : assert property (
        @(posedge clk) disable iff (rst)
        (r_state == ST_CALC) |-> (r_iter_cnt != '0)
    );

    // The counter must be able to hold WIDTH.
    a_cnt_w_fits : assert property (
        @(posedge clk) disable iff (rst)
        ((2 ** CNT_W) > WIDTH)
    );
`endif

endmodule : multiplier_control
`default_nettype wire

// File: tb/tb_multiplier_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_control
// Description : Self-checking bench for multiplier_control. A behavioural
//               Product/multiplicand datapath driven by the controller's
//               strobes closes the lsb loop. Stimulus pushes hand-computed
//               expectations into a queue; a monitor pops one whenever rdy
//               rises and checks product, add count, busy length and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_control;

    localparam int c_WIDTH = 32;
    localparam int c_CNT_W = 6;
    // Posedges from the start-sampling edge to the edge after which rdy is 1.
    localparam int c_LAT   = c_WIDTH + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               lsb;
    logic               ld_mcand;
    logic               alu_zero;
    logic               w_ctrl_Product;
    logic               adding_ctrl;
    logic               busy;
    logic               rdy;
    logic [c_CNT_W-1:0] iter_cnt;

    multiplier_control #(
        .WIDTH (c_WIDTH),
        .CNT_W (c_CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .lsb            (lsb),
        .ld_mcand       (ld_mcand),
        .alu_zero       (alu_zero),
        .w_ctrl_Product (w_ctrl_Product),
        .adding_ctrl    (adding_ctrl),
        .busy           (busy),
        .rdy            (rdy),
        .iter_cnt       (iter_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Behavioural datapath (negedge): multiplicand reg, ALU, Product reg
    // ------------------------------------------------------------------------
    logic [31:0] multiplicand  = '0;
    logic [31:0] multiplier_in = '0;
    logic [31:0] mcand_q;
    logic [63:0] product;
    logic [31:0] alu_res;
    logic [32:0] dp_sum;

    assign lsb     = product[0];
    assign alu_res = alu_zero ? 32'd0 : product[63:32];
    assign dp_sum  = adding_ctrl ? ({1'b0, product[63:32]} + {1'b0, mcand_q})
                                 : {1'b0, product[63:32]};

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            mcand_q <= '0;
        end else begin
            if (ld_mcand) mcand_q <= multiplicand;
            if (w_ctrl_Product) product <= {alu_res, multiplier_in};
            else if (busy)      product <= {dp_sum, product[31:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic [63:0] prod;
        int          adds;
        int          rdy_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: counts strobes per operation and checks on each rdy rise.
    int   mon_adds = 0;
    int   mon_busy = 0;
    int   mon_wp   = 0;
    logic rdy_q    = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            mon_adds = 0;
            mon_busy = 0;
            mon_wp   = 0;
            rdy_q    = 1'b0;
        end else begin
            if (busy)           mon_busy++;
            if (adding_ctrl)    mon_adds++;
            if (w_ctrl_Product) mon_wp++;
            if (rdy && !rdy_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rdy", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("product",      product,          mon_e.prod);
                    check("adding_count", 64'(mon_adds),    64'(mon_e.adds));
                    check("busy_cycles",  64'(mon_busy),    64'(c_WIDTH + 1));
                    check("load_strobes", 64'(mon_wp),      64'd1);
                    check("rdy_latency",  64'(cyc),         64'(mon_e.rdy_cyc));
                end
                mon_adds = 0;
                mon_busy = 0;
                mon_wp   = 0;
            end
            rdy_q = rdy;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    function automatic logic [5:0] outs();
        return {ld_mcand, alu_zero, w_ctrl_Product, adding_ctrl, busy, rdy};
    endfunction

    // Present operands and start; returns the index of the sampling edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input int adds,
                         input bit push, output int e);
        multiplicand  = a;
        multiplier_in = b;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e     = cyc;
        if (push) exp_q.push_back('{prod: prod, adds: adds, rdy_cyc: e + c_LAT});
    endtask

    task automatic wait_rdy(input string name, input int budget);
        int k = 0;
        while (!rdy && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 64'(rdy), 64'd1);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    int e;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(outs()),   64'd0);
        check("reset_iter",    64'(iter_cnt), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_outputs", 64'(outs()), 64'd0);

        // 3 * 5: Product load only in LOAD, adds on iterations 1 and 3
        issue(32'd3, 32'd5, 64'd15, 2, 1'b1, e);
        check("load_outputs", 64'(outs()), 64'b111010);
        @(posedge clk); #1;
        check("calc_first_iter", 64'(iter_cnt), 64'd32);
        check("calc_no_load",    64'(w_ctrl_Product), 64'd0);
        wait_rdy("rdy_3x5", 40);
        repeat (3) @(posedge clk);
        #1;
        check("done_holds", 64'({rdy, busy, adding_ctrl, iter_cnt}), {58'd0, 1'b1, 1'b0, 1'b0, 6'd0});

        // All-ones operands: 32 adds, wide carry chain
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 1'b1, e);
        check("rdy_drops_on_start", 64'(rdy), 64'd0);
        wait_rdy("rdy_ones", 40);

        // Zero multiplier: never adds
        issue(32'h0000_1234, 32'd0, 64'd0, 0, 1'b1, e);
        wait_rdy("rdy_zero", 40);

        // start pulsed during CALC iteration 5 is ignored
        issue(32'd6, 32'd11, 64'd66, 3, 1'b1, e);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start_cnt",  64'(iter_cnt), 64'd27);
        check("ignored_start_busy", 64'(busy),     64'd1);
        wait_rdy("rdy_ignored", 40);

        // start held high through DONE: back-to-back 12*10 then 7*9
        multiplicand  = 32'd12;
        multiplier_in = 32'd10;
        start         = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        exp_q.push_back('{prod: 64'd120, adds: 2, rdy_cyc: e + c_LAT});
        exp_q.push_back('{prod: 64'd63,  adds: 2, rdy_cyc: e + 2 * c_LAT + 1});
        @(posedge clk); #1;
        multiplicand  = 32'd7;
        multiplier_in = 32'd9;
        repeat (c_LAT) @(posedge clk);
        #1;
        check("b2b_rdy_one_cycle", 64'({rdy, busy, w_ctrl_Product}), 64'b011);
        @(posedge clk); #1;
        start = 1'b0;
        wait_rdy("rdy_b2b", 40);

        // Reset mid-CALC, at iteration 10
        issue(32'd3, 32'd5, 64'd15, 2, 1'b0, e);
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_iter", 64'(iter_cnt), 64'd23);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'(outs()),   64'd0);
        check("async_reset_iter",    64'(iter_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 64'({outs(), iter_cnt}), 64'd0);
        end

        // Recovery from IDLE; top-bit multiplicand exercises the carry-out
        issue(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1, 1'b1, e);
        wait_rdy("rdy_recover", 40);

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_multiplier_control
`default_nettype wire
